// File: rtl/query_normalizer.sv
// query_normalizer: reads one segment of SQG_SIZE raw 16-bit current samples,
// normalises it as (x - mean) / MAD and writes signed fixed-point samples
// (OUT_FRAC fractional bits) into the query FIFO feeding dtw_core.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            begins one segment when sampled in IDLE
//   running          high from the cycle after start is accepted until the segment ends
//   done             one-cycle pulse after the last output word is written
//   raw_fifo_rden    read strobe to the first-word-fall-through raw FIFO
//   raw_fifo_empty   raw FIFO empty
//   raw_fifo_data    unsigned raw sample, valid while !raw_fifo_empty
//   q_fifo_wren      write strobe to the query FIFO
//   q_fifo_full      query FIFO full
//   q_fifo_data      {16'b0, signed normalised sample}
//
// The read and write strobes follow empty/full in the same cycle, so they are
// combinational decodes of registered state; every other output is registered.

module query_normalizer #(
    parameter int unsigned SQG_SIZE = 250,
    parameter int unsigned OUT_FRAC = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        running,
    output logic        done,
    output logic        raw_fifo_rden,
    input  logic        raw_fifo_empty,
    input  logic [15:0] raw_fifo_data,
    output logic        q_fifo_wren,
    input  logic        q_fifo_full,
    output logic [31:0] q_fifo_data
);

    localparam int unsigned IDX_W     = (SQG_SIZE > 1) ? $clog2(SQG_SIZE) : 1;
    localparam int unsigned DEPTH     = 1 << IDX_W;
    localparam int unsigned DIV_W     = 32;
    localparam int unsigned CNT_W     = 5;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SQG_SIZE - 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_W - 1);
    localparam logic [DIV_W-1:0] SEG_LEN   = DIV_W'(SQG_SIZE);
    localparam logic [DIV_W-1:0] RECIP_NUM = 32'd1 << (OUT_FRAC + 16);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MEAN,
        DEV,
        MAD,
        RECIP,
        EMIT,
        DONE
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   wr_cnt;
    logic [DIV_W-1:0]   sum;
    logic [DIV_W-1:0]   dsum;
    logic [15:0]        mean;
    logic [DIV_W-1:0]   recip;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_r;
    logic [DIV_W-1:0]   div_d;
    logic [CNT_W-1:0]   div_cnt;
    logic               word_valid;
    logic               rd_done;

    logic [15:0]        sample_mem [DEPTH];

    logic [15:0]        cur_x;
    logic signed [16:0] diff;
    logic [16:0]        abs_diff;
    logic signed [49:0] prod;
    logic signed [49:0] scaled;
    logic [15:0]        y;

    logic [DIV_W:0]     rem_sh;
    logic [DIV_W:0]     rem_sub;
    logic [DIV_W-1:0]   step_q;
    logic [DIV_W-1:0]   step_r;

    // Strobes honour empty/full in the very cycle they change.
    assign raw_fifo_rden = (state == LOAD) && !raw_fifo_empty;
    assign q_fifo_wren   = (state == EMIT) && word_valid && !q_fifo_full;

    // Segment buffer; contents are don't-care outside a segment, so no reset.
    always_ff @(posedge clk) begin
        if (raw_fifo_rden) begin
            sample_mem[idx] <= raw_fifo_data;
        end
    end

    // Per-sample arithmetic: deviation from mean and scaled, saturated output.
    always_comb begin
        cur_x    = sample_mem[idx];
        diff     = $signed({1'b0, cur_x}) - $signed({1'b0, mean});
        abs_diff = diff[16] ? $unsigned(-diff) : $unsigned(diff);
        prod     = $signed({{33{diff[16]}}, diff}) * $signed({18'b0, recip});
        scaled   = prod >>> 16;
        if (scaled > 50'sd32767) begin
            y = 16'h7FFF;
        end else if (scaled < -50'sd32768) begin
            y = 16'h8000;
        end else begin
            y = scaled[15:0];
        end
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh  = {div_r, div_q[DIV_W-1]};
        rem_sub = rem_sh - {1'b0, div_d};
        if (!rem_sub[DIV_W]) begin
            step_r = rem_sub[DIV_W-1:0];
            step_q = {div_q[DIV_W-2:0], 1'b1};
        end else begin
            step_r = rem_sh[DIV_W-1:0];
            step_q = {div_q[DIV_W-2:0], 1'b0};
        end
    end

    // Control FSM with registered outputs and the shared divider iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            running     <= 1'b0;
            done        <= 1'b0;
            q_fifo_data <= '0;
            idx         <= '0;
            wr_cnt      <= '0;
            sum         <= '0;
            dsum        <= '0;
            mean        <= '0;
            recip       <= '0;
            div_q       <= '0;
            div_r       <= '0;
            div_d       <= '0;
            div_cnt     <= '0;
            word_valid  <= 1'b0;
            rd_done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        running <= 1'b1;
                        sum     <= '0;
                        idx     <= '0;
                    end
                end

                LOAD: begin
                    if (raw_fifo_rden) begin
                        sum <= sum + DIV_W'(raw_fifo_data);
                        if (idx == LAST_IDX) begin
                            state   <= MEAN;
                            idx     <= '0;
                            div_q   <= sum + DIV_W'(raw_fifo_data);
                            div_r   <= '0;
                            div_d   <= SEG_LEN;
                            div_cnt <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end

                MEAN: begin
                    div_q   <= step_q;
                    div_r   <= step_r;
                    div_cnt <= div_cnt + CNT_W'(1);
                    if (div_cnt == LAST_STEP) begin
                        state <= DEV;
                        mean  <= step_q[15:0];
                        dsum  <= '0;
                        idx   <= '0;
                    end
                end

                DEV: begin
                    dsum <= dsum + DIV_W'(abs_diff);
                    if (idx == LAST_IDX) begin
                        state   <= MAD;
                        idx     <= '0;
                        div_q   <= dsum + DIV_W'(abs_diff);
                        div_r   <= '0;
                        div_d   <= SEG_LEN;
                        div_cnt <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end

                MAD: begin
                    div_q   <= step_q;
                    div_r   <= step_r;
                    div_cnt <= div_cnt + CNT_W'(1);
                    if (div_cnt == LAST_STEP) begin
                        // A flat segment has zero deviation; divide by one instead.
                        state   <= RECIP;
                        div_q   <= RECIP_NUM;
                        div_r   <= '0;
                        div_d   <= (step_q == '0) ? DIV_W'(1) : step_q;
                        div_cnt <= '0;
                    end
                end

                RECIP: begin
                    div_q   <= step_q;
                    div_r   <= step_r;
                    div_cnt <= div_cnt + CNT_W'(1);
                    if (div_cnt == LAST_STEP) begin
                        state      <= EMIT;
                        recip      <= step_q;
                        idx        <= '0;
                        wr_cnt     <= '0;
                        word_valid <= 1'b0;
                        rd_done    <= 1'b0;
                    end
                end

                EMIT: begin
                    if (q_fifo_wren) begin
                        wr_cnt <= wr_cnt + IDX_W'(1);
                        if (wr_cnt == LAST_IDX) begin
                            state <= DONE;
                        end
                    end
                    // Output register refills when empty or being consumed; held while full.
                    if (!word_valid || q_fifo_wren) begin
                        if (!rd_done) begin
                            q_fifo_data <= {16'b0, y};
                            word_valid  <= 1'b1;
                            if (idx == LAST_IDX) begin
                                rd_done <= 1'b1;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end else begin
                            word_valid <= 1'b0;
                        end
                    end
                end

                DONE: begin
                    running <= 1'b0;
                    done    <= 1'b1;
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_query_normalizer.sv
// Self-checking bench for query_normalizer: three instances (4-sample/8-frac,
// 4-sample/15-frac, default 250-sample/8-frac) driven by a FIFO source/sink
// model, checked against hand-computed vectors and an arithmetic reference.

module tb_query_normalizer;

    logic        clk;
    logic        rst_n;
    logic        start_v   [3];
    logic        running_v [3];
    logic        done_v    [3];
    logic        rden_v    [3];
    logic        raw_empty [3];
    logic [15:0] raw_data  [3];
    logic        wren_v    [3];
    logic        q_full    [3];
    logic [31:0] qdata     [3];

    int checks = 0;
    int errors = 0;
    int of_tab [3] = '{8, 15, 8};
    int sz_tab [3] = '{4, 4, 250};

    query_normalizer #(.SQG_SIZE(4), .OUT_FRAC(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .running(running_v[0]), .done(done_v[0]),
        .raw_fifo_rden(rden_v[0]), .raw_fifo_empty(raw_empty[0]), .raw_fifo_data(raw_data[0]),
        .q_fifo_wren(wren_v[0]), .q_fifo_full(q_full[0]), .q_fifo_data(qdata[0]));

    query_normalizer #(.SQG_SIZE(4), .OUT_FRAC(15)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .running(running_v[1]), .done(done_v[1]),
        .raw_fifo_rden(rden_v[1]), .raw_fifo_empty(raw_empty[1]), .raw_fifo_data(raw_data[1]),
        .q_fifo_wren(wren_v[1]), .q_fifo_full(q_full[1]), .q_fifo_data(qdata[1]));

    query_normalizer u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .running(running_v[2]), .done(done_v[2]),
        .raw_fifo_rden(rden_v[2]), .raw_fifo_empty(raw_empty[2]), .raw_fifo_data(raw_data[2]),
        .q_fifo_wren(wren_v[2]), .q_fifo_full(q_full[2]), .q_fifo_data(qdata[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              k;
        int              ep;
        int              fp;
        logic [3:0][15:0] x;
        logic [3:0][15:0] y;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: mean/MAD/reciprocal from the normalisation rules in plain integer arithmetic.
    function automatic void model(input logic [15:0] xs[$], input int of, output logic [15:0] ys[$]);
        longint n, sum, mean, dsum, mad, recip, d, p, q;
        n = xs.size();
        sum = 0;
        foreach (xs[i]) sum += longint'(xs[i]);
        mean = sum / n;
        dsum = 0;
        foreach (xs[i]) begin
            d = longint'(xs[i]) - mean;
            dsum += (d < 0) ? -d : d;
        end
        mad = dsum / n;
        if (mad == 0) mad = 1;
        recip = (longint'(1) << (of + 16)) / mad;
        ys = {};
        foreach (xs[i]) begin
            p = (longint'(xs[i]) - mean) * recip;
            q = p / 65536;
            if (p < 0 && (p % 65536) != 0) q = q - 1;
            if (q > 32767) q = 32767;
            if (q < -32768) q = -32768;
            ys.push_back(16'(q));
        end
    endfunction

    // Drives one segment through instance k as a FWFT source and a sink with backpressure.
    task automatic run_seg(input int k, input logic [15:0] xs[$], input int ep, input int fp,
                           input int abort_after, input bit keep,
                           output logic [15:0] ys[$], output int nrd, output int nd,
                           output int viol, output bit to);
        int n, ri, cyc, tail;
        bit seen_run;
        n = xs.size(); ri = 0; cyc = 0; tail = -1; seen_run = 0;
        ys = {}; nrd = 0; nd = 0; viol = 0; to = 0;
        @(negedge clk);
        start_v[k] = 1'b1;
        while (1) begin
            raw_empty[k] = (ri >= n) || (ep != 0 && (cyc % ep) == ep - 1);
            raw_data[k]  = (ri < n) ? xs[ri] : 16'h0;
            q_full[k]    = (fp != 0 && (cyc % fp) == fp - 1);
            #2;
            if (rden_v[k] && raw_empty[k]) viol++;
            if (wren_v[k] && q_full[k]) viol++;
            if (rden_v[k] && !raw_empty[k]) begin ri++; nrd++; end
            if (wren_v[k] && !q_full[k]) begin
                ys.push_back(qdata[k][15:0]);
                if (qdata[k][31:16] != 16'h0) viol++;
            end
            if (done_v[k]) begin
                nd++;
                if (running_v[k]) viol++;
                if (tail < 0) tail = 3;
            end
            if (running_v[k]) seen_run = 1;
            else if (seen_run && !done_v[k] && tail < 0) viol++;
            if (!keep && running_v[k]) start_v[k] = 1'b0;
            if (abort_after > 0 && ys.size() >= abort_after) break;
            if (tail == 0) break;
            if (tail > 0) tail--;
            if (cyc >= 6000) begin to = 1; break; end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_seg(input int k, input logic [15:0] xs[$], input logic [15:0] exp[$],
                          input int ep, input int fp, input bit keep, input string tag);
        logic [15:0] ys[$];
        int nrd, nd, viol;
        bit to;
        run_seg(k, xs, ep, fp, 0, keep, ys, nrd, nd, viol, to);
        check($sformatf("%s timeout", tag), longint'(to), 0);
        check($sformatf("%s reads", tag), nrd, xs.size());
        check($sformatf("%s writes", tag), ys.size(), exp.size());
        check($sformatf("%s done_pulses", tag), nd, 1);
        check($sformatf("%s strobe_violations", tag), viol, 0);
        foreach (exp[i]) begin
            check($sformatf("%s word%0d", tag, i),
                  (i < ys.size()) ? longint'(ys[i]) : -1, longint'(exp[i]));
        end
    endtask

    initial begin
        logic [15:0] xs[$];
        logic [15:0] exp[$];
        logic [15:0] ys[$];
        int nrd, nd, viol, ep, fp, k, base, wren_seen;
        bit to;

        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0; raw_empty[i] = 1'b0; raw_data[i] = 16'h0; q_full[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset%0d running", i), running_v[i], 0);
            check($sformatf("reset%0d done", i), done_v[i], 0);
            check($sformatf("reset%0d rden", i), rden_v[i], 0);
            check($sformatf("reset%0d wren", i), wren_v[i], 0);
            check($sformatf("reset%0d qdata", i), qdata[i], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("idle%0d rden", i), rden_v[i], 0);
            raw_empty[i] = 1'b1;
        end

        // Hand-computed 4-sample vectors.
        vecs[0].k = 0; vecs[0].ep = 0; vecs[0].fp = 0;
        vecs[0].x = {16'd400, 16'd300, 16'd200, 16'd100};
        vecs[0].y = {16'h017F, 16'h007F, 16'hFF80, 16'hFE80};
        vecs[1].k = 0; vecs[1].ep = 0; vecs[1].fp = 0;
        vecs[1].x = {16'd500, 16'd500, 16'd500, 16'd500};
        vecs[1].y = {16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[2].k = 1; vecs[2].ep = 0; vecs[2].fp = 0;
        vecs[2].x = {16'd1000, 16'd0, 16'd0, 16'd0};
        vecs[2].y = {16'h7FFF, 16'hAAAA, 16'hAAAA, 16'hAAAA};
        vecs[3].k = 1; vecs[3].ep = 2; vecs[3].fp = 2;
        vecs[3].x = {16'd400, 16'd300, 16'd200, 16'd100};
        vecs[3].y = {16'h7FFF, 16'h3FFF, 16'hC000, 16'h8000};
        vecs[4].k = 0; vecs[4].ep = 3; vecs[4].fp = 2;
        vecs[4].x = {16'd400, 16'd300, 16'd200, 16'd100};
        vecs[4].y = {16'h017F, 16'h007F, 16'hFF80, 16'hFE80};

        for (int i = 0; i < 5; i++) begin
            xs = {}; exp = {};
            for (int j = 0; j < 4; j++) begin
                xs.push_back(vecs[i].x[j]);
                exp.push_back(vecs[i].y[j]);
            end
            do_seg(vecs[i].k, xs, exp, vecs[i].ep, vecs[i].fp, 1'b0, $sformatf("vec%0d", i));
        end

        // Random short segments on both 4-sample instances.
        for (int s = 0; s < 10; s++) begin
            k = s % 2;
            xs = {};
            base = $urandom_range(0, 65000);
            for (int j = 0; j < sz_tab[k]; j++) begin
                if (s % 3 == 0) xs.push_back(16'(base + $urandom_range(0, 3)));
                else xs.push_back(16'($urandom));
            end
            ep = $urandom_range(0, 4); if (ep == 1) ep = 0;
            fp = $urandom_range(0, 4); if (fp == 1) fp = 0;
            model(xs, of_tab[k], exp);
            do_seg(k, xs, exp, ep, fp, 1'b0, $sformatf("rnd%0d", s));
        end

        // Full-size segment with periodic empty and full.
        xs = {};
        for (int j = 0; j < 250; j++) xs.push_back(16'($urandom_range(20000, 45000)));
        model(xs, 8, exp);
        do_seg(2, xs, exp, 5, 6, 1'b0, "stall250");

        // Reset mid-EMIT, then a clean restart.
        xs = {};
        for (int j = 0; j < 250; j++) xs.push_back(16'($urandom));
        run_seg(2, xs, 0, 0, 50, 1'b0, ys, nrd, nd, viol, to);
        check("abort reached_emit", longint'(ys.size()), 50);
        q_full[2] = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort qdata", qdata[2], 0);
        check("abort wren", wren_v[2], 0);
        check("abort running", running_v[2], 0);
        check("abort done", done_v[2], 0);
        start_v[2] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wren_seen = 0;
        repeat (20) begin
            @(negedge clk);
            #2;
            if (wren_v[2] || running_v[2]) wren_seen++;
        end
        check("abort no_partial_output", wren_seen, 0);
        xs = {};
        for (int j = 0; j < 250; j++) xs.push_back(16'($urandom_range(0, 4000)));
        model(xs, 8, exp);
        do_seg(2, xs, exp, 0, 3, 1'b0, "restart");

        // start held high across two back-to-back segments.
        xs = {};
        for (int j = 0; j < 250; j++) xs.push_back(16'($urandom));
        model(xs, 8, exp);
        do_seg(2, xs, exp, 4, 0, 1'b1, "hold1");
        xs = {};
        for (int j = 0; j < 250; j++) xs.push_back(16'($urandom_range(30000, 31000)));
        model(xs, 8, exp);
        do_seg(2, xs, exp, 0, 0, 1'b1, "hold2");
        start_v[2] = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/query_normalizer.md
Name: query_normalizer

Overview:
- Upstream neighbour of dtw_core: reads one segment of SQG_SIZE raw 16-bit nanopore current samples from the raw-signal FIFO.
- Normalises the segment as (x − mean) / MAD, where MAD is the mean absolute deviation.
- Writes signed fixed-point query samples into the query FIFO that dtw_core drains through its src_fifo port.
- One sequential divider is shared for the mean and the reciprocal; per-sample scaling is a single multiply.

Parameters:
- SQG_SIZE, 250, samples per query segment (2..4095).
- OUT_FRAC, 8, fractional bits of the signed output (0..15).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  level/pulse; sampled in IDLE to begin one segment.
- running  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse after the last output word is written.
- raw_fifo_rden  out  1  read strobe, first-word-fall-through.
- raw_fifo_empty  in  1  raw FIFO empty.
- raw_fifo_data  in  16  unsigned raw sample, valid while !raw_fifo_empty.
- q_fifo_wren  out  1  write strobe to the query FIFO.
- q_fifo_full  in  1  query FIFO full.
- q_fifo_data  out  32  {16'b0, signed normalised sample}.

Behaviour:
- Reset (rst_n=0, async, any state): state=IDLE; running, done, raw_fifo_rden, q_fifo_wren = 0; q_fifo_data = 0; all counters and accumulators = 0.
- Reset mid-operation aborts the segment. No partial output follows release.
- IDLE:
  - start=1 → LOAD; clear sum and index.
  - start is ignored in every other state.
- LOAD:
  - raw_fifo_rden = !raw_fifo_empty.
  - On each rden: buf[idx] ← raw_fifo_data; sum += data (32-bit unsigned); idx++.
  - After sample SQG_SIZE−1 → MEAN.
  - Empty stalls without losing a sample.
- MEAN:
  - Shared restoring divider, 32 cycles, computes mean = floor(sum / SQG_SIZE) (16-bit).
  - → DEV.
- DEV:
  - One buffer sample per cycle; dsum += |x − mean| (17-bit signed diff, 32-bit accumulator).
  - SQG_SIZE cycles (plus 1 for RAM read latency if synchronous) → MAD.
- MAD:
  - Divider computes mad = floor(dsum / SQG_SIZE); if mad == 0, force mad = 1.
  - → RECIP.
- RECIP:
  - Divider computes recip = floor(2^(OUT_FRAC+16) / mad) (≤ 32 bits).
  - → EMIT.
- EMIT, per sample in buffer order:
  - p = (x − mean) × recip (signed, 49-bit).
  - y = p >>> 16 (arithmetic shift, floor).
  - Saturate y to [−32768, 32767].
  - Present y on q_fifo_data[15:0] with q_fifo_wren = 1 only while !q_fifo_full.
  - Word is consumed in any cycle where wren=1.
  - Full holds the current word stable; nothing is dropped or duplicated.
  - After word SQG_SIZE−1 → DONE.
  - Pipelining the multiply is allowed; ordering and backpressure rules are unchanged.
- DONE: done=1 for one cycle, running=0 → IDLE.
- raw_fifo_rden is never high outside LOAD. q_fifo_wren is never high outside EMIT.
- Input is read only while !empty; output is written only while !full, including when both strobes change in the same cycle.
- Latency: segment output starts ≥ 96 + SQG_SIZE cycles after the last input sample.

Test Plan:
- SQG_SIZE=4, OUT_FRAC=8, input 100,200,300,400 → mean 250, mad 100, recip 167772; outputs 0xFE80, 0xFF80, 0x007F, 0x017F (−384, −128, 127, 383); done pulses once.
- SQG_SIZE=4, input 500×4 → mad forced to 1; outputs 0,0,0,0; no divide-by-zero.
- SQG_SIZE=4, OUT_FRAC=15, input 0,0,0,1000 → mean 250, mad 375; outputs −21846, −21846, −21846, 32767 (saturated).
- Default params, raw_fifo_empty pulsed every 5th cycle and q_fifo_full every 6th cycle → exactly 250 reads and 250 writes; outputs match the software model sample-for-sample.
- rst_n pulsed low mid-EMIT → outputs zero immediately; after restart with start, a full new segment is produced with correct values.
- start held high through a segment → exactly one segment processed per IDLE entry; running low only in IDLE.
